mem_port_arb: RTL and testbench

Two-requester arbiter sharing the CPU's single memory port between instruction fetch and data load/store. It sits between the fetch and memory stages and the external memory interface. It grants one requester at a time with round-robin fairness and forwards that requester's address and write data. It returns read data with a one-cycle acknowledge, and aborts transactions that exceed a timeout with an error flag.

---
 rtl/mem_port_arb.sv | 130 +++++++++++++
 tb/tb_mem_port_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - round-robin arbiter sharing one memory port between fetch and data
// Grants one requester at a time, forwards its access and aborts accesses that exceed TMO cycles.
module mem_port_arb #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ack_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_ack_o,
  output logic          bus_err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t        state_q;
  logic [7:0]    cnt_q;
  logic [7:0]    cnt_d;
  logic          last_gnt_q;
  logic          if_ack_q;
  logic          d_ack_q;
  logic          bus_err_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;

  logic if_elig;
  logic d_elig;
  logic pick_d;
  logic done;

  // A request seen in its own ack cycle is the stale tail of the finished access.
  always_comb begin
    if_elig = if_req_i && !if_ack_q;
    d_elig  = d_req_i && !d_ack_q;
    pick_d  = d_elig && (!if_elig || !last_gnt_q);
    cnt_d   = cnt_q + 8'd1;
    done    = mem_ready_i || (cnt_q == TMO_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_gnt_q  <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_ack_q  <= 1'b0;
      d_ack_q   <= 1'b0;
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_elig || d_elig) begin
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            if (pick_d) begin
              state_q     <= GNT_D;
              last_gnt_q  <= 1'b1;
              mem_we_q    <= d_we_i;
              mem_addr_q  <= d_addr_i;
              mem_wdata_q <= d_wdata_i;
            end else begin
              state_q    <= GNT_I;
              last_gnt_q <= 1'b0;
              mem_we_q   <= 1'b0;
              mem_addr_q <= if_addr_i;
            end
          end
        end
        GNT_I, GNT_D: begin
          cnt_q <= cnt_d;
          // mem_ready takes priority over a timeout landing on the same edge.
          if (done) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mem_req_q <= 1'b0;
            bus_err_q <= !mem_ready_i;
            if (state_q == GNT_I) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_ready_i ? mem_rdata_i : '0;
            end else begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= mem_ready_i ? mem_rdata_i : '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_ack_o     = d_ack_q;
  assign bus_err_o   = bus_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - directed bench for mem_port_arb
module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arb #(.AW(32), .DW(32), .TMO(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_rdata_o  (if_rdata),
    .if_ack_o    (if_ack),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_rdata_o   (d_rdata),
    .d_ack_o     (d_ack),
    .bus_err_o   (bus_err),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ready_i (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    step(); step();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_if_ack", 32'(if_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    rst = 1'b0;

    // single fetch
    if_req = 1'b1; if_addr = 32'h100;
    step();
    check("fetch_mem_req", 32'(mem_req), 32'd1);
    check("fetch_mem_addr", mem_addr, 32'h100);
    check("fetch_mem_we", 32'(mem_we), 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    check("fetch_ack", 32'(if_ack), 32'd1);
    check("fetch_rdata", if_rdata, 32'hDEADBEEF);
    check("fetch_bus_err", 32'(bus_err), 32'd0);
    check("fetch_mem_req_off", 32'(mem_req), 32'd0);
    mem_ready = 1'b0; if_req = 1'b0;
    step();
    check("fetch_ack_pulse", 32'(if_ack), 32'd0);

    // both requesters held: D, I, D, I
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      step();
      check("tie_mem_req", 32'(mem_req), 32'd1);
      check("tie_mem_addr", mem_addr, (k % 2 == 0) ? 32'h300 : 32'h200);
      mem_ready = 1'b1; mem_rdata = 32'hA0000000 + 32'(k);
      step();
      check("tie_gap", 32'(mem_req), 32'd0);
      if (k % 2 == 0) begin
        check("tie_d_ack", 32'(d_ack), 32'd1);
        check("tie_if_ack_low", 32'(if_ack), 32'd0);
        check("tie_d_rdata", d_rdata, 32'hA0000000 + 32'(k));
      end else begin
        check("tie_if_ack", 32'(if_ack), 32'd1);
        check("tie_d_ack_low", 32'(d_ack), 32'd0);
        check("tie_if_rdata", if_rdata, 32'hA0000000 + 32'(k));
      end
      mem_ready = 1'b0;
      if (k == 3) begin
        if_req = 1'b0; d_req = 1'b0;
      end
    end
    step();
    check("tie_idle", 32'(mem_req), 32'd0);

    // data write, ready in third grant cycle
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55AA55AA;
    for (int g = 0; g < 3; g++) begin
      step();
      check("wr_mem_req", 32'(mem_req), 32'd1);
      check("wr_mem_we", 32'(mem_we), 32'd1);
      check("wr_mem_wdata", mem_wdata, 32'h55AA55AA);
      check("wr_mem_addr", mem_addr, 32'h20);
      check("wr_no_ack", 32'(d_ack), 32'd0);
      if (g == 2) begin
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
      end
    end
    step();
    check("wr_ack", 32'(d_ack), 32'd1);
    check("wr_bus_err", 32'(bus_err), 32'd0);
    check("wr_mem_req_off", 32'(mem_req), 32'd0);
    mem_ready = 1'b0; d_req = 1'b0; d_we = 1'b0;
    step();

    // timeout with TMO=4
    d_req = 1'b1; d_addr = 32'h40;
    for (int g = 0; g < 4; g++) begin
      step();
      check("tmo_mem_req", 32'(mem_req), 32'd1);
      check("tmo_no_ack", 32'(d_ack), 32'd0);
    end
    step();
    check("tmo_ack", 32'(d_ack), 32'd1);
    check("tmo_bus_err", 32'(bus_err), 32'd1);
    check("tmo_rdata", d_rdata, 32'd0);
    check("tmo_mem_req_off", 32'(mem_req), 32'd0);
    d_req = 1'b0;
    step();
    check("tmo_ack_pulse", 32'(d_ack), 32'd0);
    check("tmo_err_pulse", 32'(bus_err), 32'd0);

    // mem_ready on the timeout cycle
    d_req = 1'b1; d_addr = 32'h44;
    for (int g = 0; g < 4; g++) begin
      step();
      check("rdytmo_mem_req", 32'(mem_req), 32'd1);
      if (g == 3) begin
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
      end
    end
    step();
    check("rdytmo_ack", 32'(d_ack), 32'd1);
    check("rdytmo_bus_err", 32'(bus_err), 32'd0);
    check("rdytmo_rdata", d_rdata, 32'hCAFEF00D);
    mem_ready = 1'b0; d_req = 1'b0;
    step();

    // stray mem_ready in IDLE
    mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    step();
    check("idle_rdy_if_ack", 32'(if_ack), 32'd0);
    check("idle_rdy_d_ack", 32'(d_ack), 32'd0);
    check("idle_rdy_mem_req", 32'(mem_req), 32'd0);
    check("idle_rdy_d_rdata", d_rdata, 32'hCAFEF00D);
    mem_ready = 1'b0;

    // reset two cycles into a fetch grant
    if_req = 1'b1; if_addr = 32'h500;
    step();
    check("rmid_mem_addr", mem_addr, 32'h500);
    step();
    rst = 1'b1;
    step();
    check("rmid_mem_req", 32'(mem_req), 32'd0);
    check("rmid_mem_addr0", mem_addr, 32'd0);
    check("rmid_mem_wdata", mem_wdata, 32'd0);
    check("rmid_if_ack", 32'(if_ack), 32'd0);
    check("rmid_if_rdata", if_rdata, 32'd0);
    check("rmid_d_rdata", d_rdata, 32'd0);
    rst = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    step();
    check("rmid_tie_d_first", mem_addr, 32'h600);
    check("rmid_mem_req_on", 32'(mem_req), 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h600D600D;
    step();
    check("rmid_d_ack", 32'(d_ack), 32'd1);
    check("rmid_no_if_ack", 32'(if_ack), 32'd0);
    check("rmid_d_rdata", d_rdata, 32'h600D600D);
    mem_ready = 1'b0; d_req = 1'b0; if_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
